// File: rtl/fp_div_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fp_div_pkg
// Description : Shared types and per-format constants for the iterative
//               floating-point divider (state encoding, mantissa widths,
//               exponent bias and overflow limits, latencies).
// Revision    : 1.0 - initial release
// ============================================================================
package fp_div_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        DIVIDE    = 2'd1,
        NORMALIZE = 2'd2
    } state_t;

    // Quotient fraction bits per format (mantissa width including hidden 1)
    localparam int W_SP    = 24;
    localparam int W_HP    = 11;
    localparam int BIAS_SP = 127;
    localparam int BIAS_HP = 15;
    localparam int EMAX_SP = 254;
    localparam int EMAX_HP = 30;

    // Edges from the accepting edge to the edge that raises done
    localparam int LAT_SP  = W_SP + 2;
    localparam int LAT_HP  = W_HP + 2;

    // Divider datapath is sized for the widest format
    localparam int MANT_W  = W_SP;
    localparam int CNT_W   = 5;

    function automatic logic [CNT_W-1:0] fmt_iter(input logic half);
        return half ? CNT_W'(W_HP) : CNT_W'(W_SP);
    endfunction

    function automatic logic [9:0] fmt_bias(input logic half);
        return half ? 10'(BIAS_HP) : 10'(BIAS_SP);
    endfunction

    function automatic logic [9:0] fmt_emax(input logic half);
        return half ? 10'(EMAX_HP) : 10'(EMAX_SP);
    endfunction

    function automatic int fmt_latency(input logic half);
        return half ? LAT_HP : LAT_SP;
    endfunction

endpackage
`default_nettype wire

// File: rtl/fp_mant_divider.sv
`default_nettype none
// ============================================================================
// Module      : fp_mant_divider
// Description : Restoring shift-subtract mantissa divider, one quotient bit
//               per step. Produces floor(dividend * 2^W / divisor) after
//               W+1 steps, where W is the count loaded at start.
// Revision    : 1.0 - initial release
// ============================================================================
module fp_mant_divider
    import fp_div_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load_i,
    input  logic              step_i,
    input  logic [MANT_W-1:0] dividend_i,
    input  logic [MANT_W-1:0] divisor_i,
    input  logic [CNT_W-1:0]  count_i,
    output logic [MANT_W:0]   quotient_o,
    output logic              last_o
);

    logic [MANT_W:0]   rem_q, rem_d;
    logic [MANT_W-1:0] div_q, div_d;
    logic [MANT_W:0]   quo_q, quo_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic              w_ge;
    logic [MANT_W-1:0] w_diff;
    logic [MANT_W-1:0] w_keep;

    // One restoring step: subtract when possible, shift remainder, append bit
    always_comb begin
        // After a subtract the remainder is below the divisor, so the top
        // remainder bit is never needed for the difference itself.
        w_ge   = (rem_q >= {1'b0, div_q});
        w_diff = rem_q[MANT_W-1:0] - div_q;
        w_keep = w_ge ? w_diff : rem_q[MANT_W-1:0];

        rem_d  = rem_q;
        div_d  = div_q;
        quo_d  = quo_q;
        cnt_d  = cnt_q;

        if (load_i) begin
            rem_d = {1'b0, dividend_i};
            div_d = divisor_i;
            quo_d = '0;
            cnt_d = count_i;
        end else if (step_i) begin
            rem_d = {w_keep, 1'b0};
            quo_d = {quo_q[MANT_W-1:0], w_ge};
            if (cnt_q != '0) begin
                cnt_d = cnt_q - 1'b1;
            end
        end
    end

    // Divider state registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rem_q <= '0;
            div_q <= '0;
            quo_q <= '0;
            cnt_q <= '0;
        end else begin
            rem_q <= rem_d;
            div_q <= div_d;
            quo_q <= quo_d;
            cnt_q <= cnt_d;
        end
    end

    assign quotient_o = quo_q;
    assign last_o     = (cnt_q == '0);

endmodule
`default_nettype wire

// File: rtl/floating_point_divider.sv
`default_nettype none
// ============================================================================
// Module      : floating_point_divider
// Description : Iterative IEEE-style divider (normalized operands only,
//               truncating). Single precision always; half precision on
//               selector=1 when built with macro FP_DIV_HALF_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module floating_point_divider
    import fp_div_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        selector,
    output logic        busy,
    output logic        done,
    output logic [31:0] quotient,
    output logic        div_by_zero
);

    state_t            state_q, state_d;
    logic [31:0]       a_q, b_q;
    logic [31:0]       quot_q;
    logic              done_q;
    logic              dbz_q;

    logic              w_load, w_step, w_last;
    logic [MANT_W-1:0] w_ma_in, w_mb_in;
    logic [CNT_W-1:0]  w_iter;
    logic [MANT_W:0]   w_q;

    logic              w_sign, w_a_zero, w_b_zero, w_qtop;
    logic              w_ovf, w_zero;
    logic [7:0]        w_ea, w_eb;
    logic [22:0]       w_mant;
    logic [9:0]        w_exp, w_emax;
    logic [31:0]       w_result;

`ifdef FP_DIV_HALF_EN
    logic              half_q;
`else
    logic              w_unused_selector;
    assign w_unused_selector = selector;
`endif

    // Control: accept in IDLE, iterate in DIVIDE, pack result in NORMALIZE
    always_comb begin
        state_d = state_q;
        w_load  = 1'b0;
        w_step  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = DIVIDE;
                    w_load  = 1'b1;
                end
            end
            DIVIDE: begin
                w_step = 1'b1;
                if (w_last) begin
                    state_d = NORMALIZE;
                end
            end
            NORMALIZE: state_d = IDLE;
            default:   state_d = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Mantissas with hidden 1 and step count, taken from the ports at accept
    always_comb begin
        w_ma_in = {1'b1, a[22:0]};
        w_mb_in = {1'b1, b[22:0]};
        w_iter  = fmt_iter(1'b0);
`ifdef FP_DIV_HALF_EN
        if (selector) begin
            w_ma_in = {13'd0, 1'b1, a[9:0]};
            w_mb_in = {13'd0, 1'b1, b[9:0]};
            w_iter  = fmt_iter(1'b1);
        end
`endif
    end

    fp_mant_divider u_mant_div (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_i     (w_load),
        .step_i     (w_step),
        .dividend_i (w_ma_in),
        .divisor_i  (w_mb_in),
        .count_i    (w_iter),
        .quotient_o (w_q),
        .last_o     (w_last)
    );

    // Sign, exponent, normalization and special-case packing of the result
    always_comb begin
        w_sign   = a_q[31] ^ b_q[31];
        w_ea     = a_q[30:23];
        w_eb     = b_q[30:23];
        w_a_zero = (a_q[30:0] == 31'd0);
        w_b_zero = (b_q[30:0] == 31'd0);
        w_qtop   = w_q[W_SP];
        w_mant   = w_qtop ? w_q[W_SP-1:1] : w_q[W_SP-2:0];
        // Ten-bit two's complement keeps underflow visible as a negative value
        w_exp    = {2'b00, w_ea} - {2'b00, w_eb} + fmt_bias(1'b0) - {9'd0, ~w_qtop};
        w_emax   = fmt_emax(1'b0);
`ifdef FP_DIV_HALF_EN
        if (half_q) begin
            w_sign   = a_q[15] ^ b_q[15];
            w_ea     = {3'd0, a_q[14:10]};
            w_eb     = {3'd0, b_q[14:10]};
            w_a_zero = (a_q[14:0] == 15'd0);
            w_b_zero = (b_q[14:0] == 15'd0);
            w_qtop   = w_q[W_HP];
            w_mant   = {13'd0, (w_qtop ? w_q[W_HP-1:1] : w_q[W_HP-2:0])};
            w_exp    = {2'b00, w_ea} - {2'b00, w_eb} + fmt_bias(1'b1) - {9'd0, ~w_qtop};
            w_emax   = fmt_emax(1'b1);
        end
`endif
        // Divide-by-zero wins over a zero dividend (0/0 reports infinity)
        w_ovf  = w_b_zero || (!w_a_zero && !w_exp[9] && (w_exp > w_emax));
        w_zero = !w_b_zero && (w_a_zero || w_exp[9] || (w_exp == 10'd0));

        w_result = {w_sign, w_exp[7:0], w_mant};
        if (w_ovf) begin
            w_result = {w_sign, 8'hFF, 23'd0};
        end else if (w_zero) begin
            w_result = {w_sign, 31'd0};
        end
`ifdef FP_DIV_HALF_EN
        if (half_q) begin
            w_result = {16'd0, w_sign, w_exp[4:0], w_mant[9:0]};
            if (w_ovf) begin
                w_result = {16'd0, w_sign, 5'h1F, 10'd0};
            end else if (w_zero) begin
                w_result = {16'd0, w_sign, 15'd0};
            end
        end
`endif
    end

    // Operand capture at accept; result, flag and done pulse on NORMALIZE edge
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_q    <= '0;
            b_q    <= '0;
            quot_q <= '0;
            dbz_q  <= 1'b0;
            done_q <= 1'b0;
`ifdef FP_DIV_HALF_EN
            half_q <= 1'b0;
`endif
        end else begin
            done_q <= (state_q == NORMALIZE);
            if (w_load) begin
                a_q    <= a;
                b_q    <= b;
`ifdef FP_DIV_HALF_EN
                half_q <= selector;
`endif
            end
            if (state_q == NORMALIZE) begin
                quot_q <= w_result;
                dbz_q  <= w_b_zero;
            end
        end
    end

    assign busy        = (state_q != IDLE);
    assign done        = done_q;
    assign quotient    = quot_q;
    assign div_by_zero = dbz_q;

endmodule
`default_nettype wire

// File: tb/tb_floating_point_divider.sv
`default_nettype none
// ============================================================================
// Module      : tb_floating_point_divider
// Description : Self-checking bench for floating_point_divider. A cycle-level
//               reference model is checked against the DUT every cycle, and
//               directed vectors check literal results and latencies.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_floating_point_divider;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [31:0] a;
    logic [31:0] b;
    logic        selector;
    logic        busy;
    logic        done;
    logic [31:0] quotient;
    logic        div_by_zero;

    int checks = 0;
    int errors = 0;

`ifdef FP_DIV_HALF_EN
    localparam logic HALF_EN = 1'b1;
`else
    localparam logic HALF_EN = 1'b0;
`endif

    always #5 clk = ~clk;

    floating_point_divider dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .a           (a),
        .b           (b),
        .selector    (selector),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .div_by_zero (div_by_zero)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, expv);
        end
    endtask

    // Reference: real-valued mantissa ratio via integer arithmetic, then the
    // exponent/special-case rules of the format.
    function automatic logic [31:0] fp_model(input logic [31:0] fa, input logic [31:0] fb,
                                             input logic half, output logic dbz);
        int     w, bias, emax, ea, eb, e;
        longint ma, mb, q, mant;
        logic   s, a_zero;
        if (half) begin
            s = fa[15] ^ fb[15];
            ea = fa[14:10]; eb = fb[14:10];
            ma = 64'd1024 + fa[9:0]; mb = 64'd1024 + fb[9:0];
            w = 11; bias = 15; emax = 30;
            a_zero = (fa[14:0] == 15'd0);
            dbz    = (fb[14:0] == 15'd0);
        end else begin
            s = fa[31] ^ fb[31];
            ea = fa[30:23]; eb = fb[30:23];
            ma = 64'h800000 + fa[22:0]; mb = 64'h800000 + fb[22:0];
            w = 24; bias = 127; emax = 254;
            a_zero = (fa[30:0] == 31'd0);
            dbz    = (fb[30:0] == 31'd0);
        end
        q = (ma << w) / mb;
        e = ea - eb + bias;
        if (q >= (longint'(1) << w)) begin
            mant = q >> 1;
        end else begin
            mant = q;
            e = e - 1;
        end
        mant = mant % (longint'(1) << (w - 1));
        if (dbz || (!a_zero && e > emax)) begin
            return half ? {16'd0, s, 5'h1F, 10'd0} : {s, 8'hFF, 23'd0};
        end
        if (a_zero || e < 1) begin
            return half ? {16'd0, s, 15'd0} : {s, 31'd0};
        end
        return half ? {16'd0, s, 5'(e), 10'(mant)} : {s, 8'(e), 23'(mant)};
    endfunction

    // Cycle model: latency counter, pending result, held outputs
    int          m_cnt;
    logic        m_done, m_dbz, p_dbz;
    logic [31:0] m_q, p_q;

    initial begin : compare
        m_cnt = 0; m_done = 1'b0; m_dbz = 1'b0; m_q = '0; p_q = '0; p_dbz = 1'b0;
        forever begin
            @(posedge clk);
            if (!rst_n) begin
                m_cnt = 0; m_done = 1'b0; m_q = '0; m_dbz = 1'b0;
            end else begin
                m_done = 1'b0;
                if (m_cnt != 0) begin
                    m_cnt--;
                    if (m_cnt == 0) begin
                        m_done = 1'b1; m_q = p_q; m_dbz = p_dbz;
                    end
                end else if (start) begin
                    p_q   = fp_model(a, b, selector & HALF_EN, p_dbz);
                    m_cnt = (selector & HALF_EN) ? 13 : 26;
                end
            end
            @(negedge clk);
            check("cyc busy", {31'd0, busy}, {31'd0, (m_cnt != 0)});
            check("cyc done", {31'd0, done}, {31'd0, m_done});
            check("cyc quotient", quotient, m_q);
            check("cyc div_by_zero", {31'd0, div_by_zero}, {31'd0, m_dbz});
        end
    end

    // One operation: literal result, latency and busy duration; optional
    // start pulse with scrambled operands at edge 'poke' after accept.
    task automatic run_op(input string name, input logic [31:0] ta, input logic [31:0] tb,
                          input logic tsel, input logic [31:0] expq, input logic expdbz,
                          input int explat, input int poke);
        int          n, nbusy;
        logic        mdbz;
        logic [31:0] mq;
        mq = fp_model(ta, tb, tsel & HALF_EN, mdbz);
        check({name, " model"}, mq, expq);
        @(negedge clk);
        a = ta; b = tb; selector = tsel; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0; a = ~ta; b = tb ^ 32'h0055_5555; selector = ~tsel;
        n = 0; nbusy = 0;
        while (!done && n < 60) begin
            if (busy) nbusy++;
            @(posedge clk);
            n++;
            @(negedge clk);
            start = (n == poke);
        end
        start = 1'b0;
        check({name, " latency"}, n, explat);
        check({name, " busy cycles"}, nbusy, explat);
        check({name, " quotient"}, quotient, expq);
        check({name, " div_by_zero"}, {31'd0, div_by_zero}, {31'd0, expdbz});
    endtask

    initial begin : main
        int n;
        rst_n = 1'b0; start = 1'b0; a = '0; b = '0; selector = 1'b0;
        repeat (3) @(negedge clk);
        check("reset busy", {31'd0, busy}, 32'd0);
        check("reset done", {31'd0, done}, 32'd0);
        check("reset quotient", quotient, 32'd0);
        check("reset div_by_zero", {31'd0, div_by_zero}, 32'd0);
        rst_n = 1'b1;

        run_op("6/2", 32'h40C00000, 32'h40000000, 1'b0, 32'h40400000, 1'b0, 26, -1);
`ifdef FP_DIV_HALF_EN
        run_op("half 1/3", 32'h00003C00, 32'h00004200, 1'b1, 32'h00003555, 1'b0, 13, -1);
`else
        run_op("selector ignored", 32'h40C00000, 32'h40000000, 1'b1, 32'h40400000, 1'b0, 26, -1);
`endif
        run_op("1/-0", 32'h3F800000, 32'h80000000, 1'b0, 32'hFF800000, 1'b1, 26, -1);
        run_op("1/1", 32'h3F800000, 32'h3F800000, 1'b0, 32'h3F800000, 1'b0, 26, -1);
        run_op("overflow", 32'h7F000000, 32'h00800000, 1'b0, 32'h7F800000, 1'b0, 26, -1);
        run_op("underflow", 32'h00800000, 32'h7F000000, 1'b0, 32'h00000000, 1'b0, 26, -1);
        run_op("-0/2", 32'h80000000, 32'h40000000, 1'b0, 32'h80000000, 1'b0, 26, -1);
        run_op("1/3 mid start", 32'h3F800000, 32'h40400000, 1'b0, 32'h3EAAAAAA, 1'b0, 26, 10);

        // Back-to-back: start held high through the done cycle
        @(negedge clk);
        a = 32'h40C00000; b = 32'h40000000; selector = 1'b0; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        a = 32'h3F800000; b = 32'h3F800000;
        n = 0;
        while (!done && n < 60) begin
            @(posedge clk); n++; @(negedge clk);
        end
        check("b2b first latency", n, 26);
        check("b2b first quotient", quotient, 32'h40400000);
        n = 0;
        do begin
            @(posedge clk); n++; @(negedge clk);
            if (n == 1) start = 1'b0;
        end while (!done && n < 60);
        start = 1'b0;
        check("b2b second latency", n, 27);
        check("b2b second quotient", quotient, 32'h3F800000);

        // Reset in the middle of DIVIDE, with start asserted during reset
        @(negedge clk);
        a = 32'hC0C00000; b = 32'h40000000; selector = 1'b0; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (8) @(negedge clk);
        rst_n = 1'b0; start = 1'b1;
        @(negedge clk);
        rst_n = 1'b1; start = 1'b0;
        check("abort busy", {31'd0, busy}, 32'd0);
        check("abort done", {31'd0, done}, 32'd0);
        check("abort quotient", quotient, 32'd0);
        n = 0;
        repeat (30) begin
            @(negedge clk);
            if (done) n++;
        end
        check("abort no done", n, 0);

        run_op("-6/2 after reset", 32'hC0C00000, 32'h40000000, 1'b0, 32'hC0400000, 1'b0, 26, -1);

        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/floating_point_divider.md
FLOATING_POINT_DIVIDER -- requirements
Module: floating_point_divider

Interface
REQ-001 SHALL have port: clk  input  1  rising-edge clock, the only clock.
REQ-002 SHALL have port: rst_n  input  1  reset, synchronous, active-low.
REQ-003 SHALL have port: start  input  1  request a division; sampled only in IDLE.
REQ-004 SHALL have port: a  input  32  dividend; single = a[31:0], half = a[15:0].
REQ-005 SHALL have port: b  input  32  divisor; same packing as a.
REQ-006 SHALL have port: selector  input  1  1 = half (1/5/10, bias 15), 0 = single (1/8/23, bias 127).
REQ-007 SHALL have port: busy  output  1  operation in progress.
REQ-008 SHALL have port: done  output  1  one-cycle pulse; quotient valid.
REQ-009 SHALL have port: quotient  output  32  result; half mode packs result in [15:0], [31:16] = 0.
REQ-010 SHALL have port: div_by_zero  output  1  divisor magnitude zero for the last operation.

Function
REQ-011 SHALL use FSM states IDLE, DIVIDE, NORMALIZE; IDLE->DIVIDE on start=1, DIVIDE->NORMALIZE when iteration count reaches 0, NORMALIZE->IDLE unconditionally.
REQ-012 SHALL register a, b, selector on the accepting edge; later input changes have no effect on the result.
REQ-013 SHALL ignore start while busy=1; busy SHALL be 1 in DIVIDE and NORMALIZE only.
REQ-014 SHALL treat all operands as normalized with implicit leading 1 (no denormals, no NaN handling), as the multiplier does.
REQ-015 SHALL compute q = floor(ma * 2^W / mb) by restoring shift-subtract, one bit per cycle; W = 24 single, 11 half; DIVIDE lasts W+1 cycles (25 / 12).
REQ-016 SHALL normalize: if q[W]=1, mantissa = q[W-1:1], exp = ea - eb + bias; else mantissa = q[W-2:0], exp = ea - eb + bias - 1; truncation only, no rounding.
REQ-017 SHALL evaluate exponent in 10-bit signed arithmetic; exp > 254 (single) / > 30 (half) yields {sign, all-ones exponent, zero mantissa}.
REQ-018 SHALL flush exp < 1 to signed zero {sign, 0, 0}.
REQ-019 SHALL produce sign = sign_a XOR sign_b in every case, including special results.
REQ-020 SHALL, when divisor exponent and mantissa are both zero, return signed infinity and set div_by_zero=1, with unchanged latency.
REQ-021 SHALL, when dividend magnitude is zero and divisor nonzero, return signed zero.
REQ-022 SHALL register quotient and pulse done on the NORMALIZE edge: done high after edge W+2 counted from the accepting edge (26 single, 13 half), for exactly one cycle.
REQ-023 SHALL hold quotient and div_by_zero stable until the next result is written.
REQ-024 SHALL accept a new start in the cycle done is high (back-to-back, one IDLE cycle).

Reset
REQ-025 SHALL on rst_n=0 at a clock edge force IDLE, busy=0, done=0, quotient=0, div_by_zero=0, iteration counter=0.
REQ-026 SHALL abort any operation in progress on reset with no done pulse; start sampled in the reset cycle is ignored.

Configuration
REQ-027 SHALL with FP_DIV_HALF_EN defined support half mode per selector.
REQ-028 SHALL without FP_DIV_HALF_EN ignore selector, always operate single precision, omit half-mode datapath.

Structure
REQ-029 SHALL place state typedef, W/bias/exponent-limit constants per format, and latency constants in package fp_div_pkg.
REQ-030 SHALL implement the iterative mantissa divider (remainder/divisor registers, count, step logic) as sub-module fp_mant_divider; top holds FSM, sign/exponent and packing.

Verification
REQ-031 SHALL cover: single a=0x40C00000, b=0x40000000 -> quotient 0x40400000, done 26 edges after accept, busy high throughout.
REQ-032 SHALL cover: half (selector=1) a=0x3C00, b=0x4200 -> quotient 0x00003555, done after 13 edges.
REQ-033 SHALL cover: a=0x3F800000, b=0x80000000 -> 0xFF800000, div_by_zero=1; next op b=0x3F800000 clears div_by_zero.
REQ-034 SHALL cover: a=0x7F000000, b=0x00800000 -> 0x7F800000; a=0x00800000, b=0x7F000000 -> 0x00000000.
REQ-035 SHALL cover: start pulsed mid-DIVIDE ignored (result of first op unchanged); rst_n=0 mid-DIVIDE -> IDLE, no done, quotient=0.
REQ-036 SHALL cover: start held high across done -> second op accepted at done cycle, completes 26 edges later.
